alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 126 ++++++++++++
 tb/tb_alu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// rtl/alu.sv - registered single-cycle ALU with optional multiplier
//
// Purpose: samples a, b and op on every rising clk edge and registers the
// result and carry/borrow/shift-out flag, giving exactly one cycle of latency
// with a new operation accepted every cycle.
//
// Ports:
//   clk    in   clock; all state updates on the rising edge
//   rst_n  in   synchronous active-low reset; clears out and c
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B (ignored for ops 5..11)
//   op     in   4      operation select
//   out    out  WIDTH  registered result
//   c      out  1      registered carry / borrow / shift-out / overflow flag
//
// Configuration macro: ALU_MUL_EN -- when defined, op 12 is an unsigned
// multiply (low half to out, c flags a non-zero high half); when undefined
// no multiplier exists and op 12 behaves as a reserved op.

module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             c
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  logic [WIDTH-1:0] out_q, out_d;
  logic             c_q, c_d;

  // Arithmetic is done one bit wider so the top bit is the carry (add/inc)
  // or the unsigned borrow (sub/dec) without any extra comparison.
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;
  logic [WIDTH:0] inc_w;
  logic [WIDTH:0] dec_w;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign inc_w  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_w  = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_w;

  assign prod_w = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  always_comb begin
    out_d = '0;
    c_d   = 1'b0;
    case (op)
      OP_ADD: {c_d, out_d} = sum_w;
      OP_SUB: {c_d, out_d} = diff_w;
      OP_AND: out_d = a & b;
      OP_OR:  out_d = a | b;
      OP_XOR: out_d = a ^ b;
      OP_NOT: out_d = ~a;
      OP_SHL: begin
        out_d = {a[WIDTH-2:0], 1'b0};
        c_d   = a[WIDTH-1];
      end
      OP_SHR: begin
        out_d = {1'b0, a[WIDTH-1:1]};
        c_d   = a[0];
      end
      OP_ROL: begin
        out_d = {a[WIDTH-2:0], a[WIDTH-1]};
        c_d   = a[WIDTH-1];
      end
      OP_ROR: begin
        out_d = {a[0], a[WIDTH-1:1]};
        c_d   = a[0];
      end
      OP_INC: {c_d, out_d} = inc_w;
      OP_DEC: {c_d, out_d} = dec_w;
`ifdef ALU_MUL_EN
      OP_MUL: begin
        out_d = prod_w[WIDTH-1:0];
        c_d   = |prod_w[2*WIDTH-1:WIDTH];
      end
`else
      OP_MUL: begin
        out_d = '0;
        c_d   = 1'b0;
      end
`endif
      default: begin
        out_d = '0;
        c_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      c_q   <= 1'b0;
    end else begin
      out_q <= out_d;
      c_q   <= c_d;
    end
  end

  assign out = out_q;
  assign c   = c_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu (WIDTH=8)

module tb_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic [W-1:0] out;
  logic         c;

  int total;
  int bad;

  alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .out   (out),
    .c     (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain unsigned integer arithmetic on 0..255 values.
  function automatic logic [8:0] model(input int unsigned x, input int unsigned y,
                                       input int unsigned o);
    int unsigned r;
    logic        cv;
    r  = 0;
    cv = 1'b0;
    case (o)
      0:  begin r = (x + y) % 256;       cv = (x + y) >= 256; end
      1:  begin r = (x + 256 - y) % 256; cv = x < y;          end
      2:  r = x & y;
      3:  r = x | y;
      4:  r = x ^ y;
      5:  r = 255 - x;
      6:  begin r = (x * 2) % 256;       cv = x >= 128;       end
      7:  begin r = x / 2;               cv = (x % 2) == 1;   end
      8:  begin r = (x * 2) % 256 + x / 128; cv = x >= 128;   end
      9:  begin r = x / 2 + (x % 2) * 128;   cv = (x % 2) == 1; end
      10: begin r = (x + 1) % 256;       cv = x == 255;       end
      11: begin r = (x + 255) % 256;     cv = x == 0;         end
`ifdef ALU_MUL_EN
      12: begin r = (x * y) % 256;       cv = (x * y) >= 256; end
`endif
      default: begin r = 0; cv = 1'b0; end
    endcase
    return {cv, 8'(r)};
  endfunction

  task automatic drive(input logic rn, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [3:0] top);
    rst_n = rn;
    a     = ta;
    b     = tb;
    op    = top;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 8'hFF, 8'h01, 4'd0);
    total++;
    if ({c, out} !== 9'h000) begin
      bad++;
      $display("FAIL reset_edge1 got c=%0d out=%02h want c=0 out=00", c, out);
    end
    drive(1'b0, 8'hFF, 8'h01, 4'd0);
    total++;
    if ({c, out} !== 9'h000) begin
      bad++;
      $display("FAIL reset_edge2 got c=%0d out=%02h want c=0 out=00", c, out);
    end
    drive(1'b1, 8'hFF, 8'h01, 4'd0);
    total++;
    if ({c, out} !== 9'h100) begin
      bad++;
      $display("FAIL reset_release got c=%0d out=%02h want c=1 out=00", c, out);
    end
    // Asserting reset between edges must not disturb the registered result.
    rst_n = 1'b0;
    #3;
    total++;
    if ({c, out} !== 9'h100) begin
      bad++;
      $display("FAIL reset_no_async got c=%0d out=%02h want c=1 out=00", c, out);
    end
    @(posedge clk);
    #1;
    total++;
    if ({c, out} !== 9'h000) begin
      bad++;
      $display("FAIL reset_sync_clear got c=%0d out=%02h want c=0 out=00", c, out);
    end
  endtask

  task automatic test_sub();
    drive(1'b1, 8'h05, 8'h07, 4'd1);
    total++;
    if ({c, out} !== 9'h1FE) begin
      bad++;
      $display("FAIL sub_borrow got c=%0d out=%02h want c=1 out=fe", c, out);
    end
    drive(1'b1, 8'h07, 8'h05, 4'd1);
    total++;
    if ({c, out} !== 9'h002) begin
      bad++;
      $display("FAIL sub_noborrow got c=%0d out=%02h want c=0 out=02", c, out);
    end
  endtask

  task automatic test_shifts();
    logic [8:0] want [4];
    want[0] = 9'h102;
    want[1] = 9'h140;
    want[2] = 9'h103;
    want[3] = 9'h1C0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h81, 8'h5A, 4'(6 + i));
      total++;
      if ({c, out} !== want[i]) begin
        bad++;
        $display("FAIL shift_op%0d got c=%0d out=%02h want c=%0d out=%02h",
                 6 + i, c, out, want[i][8], want[i][7:0]);
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 8'hFF, 8'h01, 4'd0);
    total++;
    if ({c, out} !== 9'h100) begin
      bad++;
      $display("FAIL wrap_add got c=%0d out=%02h want c=1 out=00", c, out);
    end
    drive(1'b1, 8'hFF, 8'h33, 4'd10);
    total++;
    if ({c, out} !== 9'h100) begin
      bad++;
      $display("FAIL wrap_inc got c=%0d out=%02h want c=1 out=00", c, out);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'h00, 8'hC3, 4'd10);
    total++;
    if ({c, out} !== 9'h001) begin
      bad++;
      $display("FAIL b2b_inc got c=%0d out=%02h want c=0 out=01", c, out);
    end
    drive(1'b1, 8'h00, 8'h3C, 4'd11);
    total++;
    if ({c, out} !== 9'h1FF) begin
      bad++;
      $display("FAIL b2b_dec got c=%0d out=%02h want c=1 out=ff", c, out);
    end
  endtask

  task automatic test_reserved_mul();
    logic [8:0] want_mul;
`ifdef ALU_MUL_EN
    want_mul = 9'h100;
`else
    want_mul = 9'h000;
`endif
    drive(1'b1, 8'hFF, 8'h01, 4'd0);
    drive(1'b1, 8'hAA, 8'hAA, 4'd13);
    total++;
    if ({c, out} !== 9'h000) begin
      bad++;
      $display("FAIL reserved_13 got c=%0d out=%02h want c=0 out=00", c, out);
    end
    drive(1'b1, 8'hFF, 8'h01, 4'd0);
    drive(1'b1, 8'h10, 8'h10, 4'd12);
    total++;
    if ({c, out} !== want_mul) begin
      bad++;
      $display("FAIL mul_op12 got c=%0d out=%02h want c=%0d out=%02h",
               c, out, want_mul[8], want_mul[7:0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    logic [3:0] rop;
    logic       rr;
    logic [8:0] exp;
    for (int i = 0; i < 4000; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 15));
      rr  = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      exp = rr ? model(ra, rb, rop) : 9'h000;
      drive(rr, ra, rb, rop);
      total++;
      if ({c, out} !== exp) begin
        bad++;
        $display("FAIL random_%0d rst_n=%0d op=%0d a=%02h b=%02h got c=%0d out=%02h want c=%0d out=%02h",
                 i, rr, rop, ra, rb, c, out, exp[8], exp[7:0]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    op    = '0;
    #2;
    test_reset();
    test_sub();
    test_shifts();
    test_wrap();
    test_back_to_back();
    test_reserved_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
